// File: rtl/uart_csr.sv
// UART control/status register file: bus-side registers, frame format, FIFO watermarks,
// RX prefetch holding register, idle-timeout and error interrupts.
module uart_csr #(
  parameter int          FIFO_ADDR_WIDTH  = 3,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'h0004
) (
  input  logic                     uart_clk,
  input  logic                     rst_n,
  input  logic [3:0]               reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic                     reg_wen,
  input  logic                     reg_ren,
  output logic [31:0]              reg_rdata,
  output logic                     reg_error,
  output logic [7:0]               wr_data,
  output logic                     wr_en,
  input  logic                     tx_empty,
  input  logic                     tx_full,
  input  logic                     tx_active,
  input  logic [FIFO_ADDR_WIDTH:0] tx_level,
  input  logic [7:0]               rx_data,
  output logic                     rd_en,
  input  logic                     rx_empty,
  input  logic                     rx_full,
  input  logic                     rx_active,
  input  logic [FIFO_ADDR_WIDTH:0] rx_level,
  input  logic                     frame_error,
  input  logic                     overrun_error,
  input  logic                     parity_error,
  input  logic                     bit_tick,
  output logic [15:0]              baud_divisor,
  output logic                     baud_enable,
  output logic [1:0]               data_bits,
  output logic [1:0]               parity_mode,
  output logic                     stop2,
  output logic                     loopback,
  output logic                     tx_fifo_rst,
  output logic                     rx_fifo_rst,
  output logic                     irq
);
  localparam int LW = FIFO_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] RX_WM_RST = LW'((1 << FIFO_ADDR_WIDTH) / 2);
  localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_TXD = 4'd2, A_RXD = 4'd3,
                         A_BAUD = 4'd4, A_IEN = 4'd5, A_IST = 4'd6, A_FIFO = 4'd7,
                         A_WM = 4'd8, A_TMO = 4'd9;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} rx_state_t;

  rx_state_t   rx_state_reg;
  logic [7:0]  hold_data_reg;
  logic [7:0]  ctrl_reg;
  logic [15:0] baud_reg;
  logic [5:0]  int_en_reg, int_status_reg, int_status_next, int_set, int_clr;
  logic [2:0]  sticky_reg, sticky_next;
  logic [LW-1:0] tx_wm_reg, rx_wm_reg, rx_level_prev_reg;
  logic [7:0]  timeout_reg;
  logic        tx_fifo_rst_reg, rx_fifo_rst_reg, reg_error_reg;
  logic [31:0] reg_rdata_reg, rdata_mux;
  logic        tx_low_prev_reg, rx_high_prev_reg;
  logic [11:0] tmo_cnt_reg, tmo_cnt_next, tmo_limit;
  logic        wr_reject, rd_reject, wr_acc, rx_read, hold_valid;
  logic        tx_low_cond, rx_high_cond, tmo_run, tmo_clear, tmo_step, tmo_hit;
  logic        unused_bits;

  assign unused_bits = ^reg_wdata;

  // Access checking: rejected writes are blocked from every register update below.
  assign wr_reject = reg_wen && (reg_addr >= 4'd10 || reg_addr == A_STATUS ||
                                 reg_addr == A_RXD || (reg_addr == A_TXD && tx_full));
  assign rd_reject = reg_ren && (reg_addr >= 4'd10 || reg_addr == A_TXD);
  assign wr_acc    = reg_wen && !wr_reject;
  assign rx_read   = reg_ren && reg_addr == A_RXD;
  assign hold_valid = (rx_state_reg == HOLD);

  assign wr_en   = wr_acc && reg_addr == A_TXD;
  assign wr_data = reg_wdata[7:0];
  assign rd_en   = !rx_fifo_rst_reg && !rx_empty &&
                   (rx_state_reg == IDLE || (rx_state_reg == HOLD && rx_read));

  assign tx_low_cond  = tx_level <= tx_wm_reg;
  assign rx_high_cond = rx_level >= rx_wm_reg;

  assign tmo_limit = 12'(timeout_reg) * 12'd10;
  assign tmo_run   = (hold_valid || !rx_empty) && timeout_reg != 8'd0;
  assign tmo_clear = !tmo_run || rx_level > rx_level_prev_reg || rx_read ||
                     (wr_acc && reg_addr == A_TMO);
  assign tmo_step  = bit_tick && !rx_active && tmo_cnt_reg != tmo_limit;
  assign tmo_hit   = !tmo_clear && tmo_step && (tmo_cnt_reg + 12'd1 == tmo_limit);

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (tmo_clear)
      tmo_cnt_next = '0;
    else if (tmo_step)
      tmo_cnt_next = tmo_cnt_reg + 12'd1;
  end

  assign int_set = {tmo_hit, parity_error, overrun_error, frame_error,
                    ctrl_reg[1] && rx_high_cond && !rx_high_prev_reg,
                    ctrl_reg[0] && tx_low_cond && !tx_low_prev_reg};
  assign int_clr = (wr_acc && reg_addr == A_IST) ? reg_wdata[5:0] : 6'd0;

  // A set event in the same cycle as its W1C clear wins.
  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_int
    assign int_status_next[gi] = (int_status_reg[gi] & ~int_clr[gi]) | int_set[gi];
  end
  for (gi = 0; gi < 3; gi++) begin : g_sticky
    assign sticky_next[gi] = (sticky_reg[gi] & ~int_clr[gi+2]) | int_set[gi+2];
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_addr)
      A_CTRL:   rdata_mux[7:0] = ctrl_reg;
      A_STATUS: rdata_mux = {8'(tx_level), 8'(rx_level), 6'd0, hold_valid,
                             sticky_reg[2], sticky_reg[1], sticky_reg[0],
                             rx_active, tx_active, rx_full, rx_empty, tx_full, tx_empty};
      A_RXD:    rdata_mux[8:0] = hold_valid ? {1'b1, hold_data_reg} : 9'd0;
      A_BAUD:   rdata_mux[15:0] = baud_reg;
      A_IEN:    rdata_mux[5:0] = int_en_reg;
      A_IST:    rdata_mux[5:0] = int_status_reg;
      A_WM: begin
        rdata_mux[LW-1:0]  = tx_wm_reg;
        rdata_mux[8 +: LW] = rx_wm_reg;
      end
      A_TMO:    rdata_mux[7:0] = timeout_reg;
      default:  rdata_mux = '0;
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg          <= 8'h0C;
      baud_reg          <= DEFAULT_BAUD_DIV;
      int_en_reg        <= '0;
      int_status_reg    <= '0;
      sticky_reg        <= '0;
      tx_wm_reg         <= LW'(1);
      rx_wm_reg         <= RX_WM_RST;
      timeout_reg       <= '0;
      tx_fifo_rst_reg   <= 1'b0;
      rx_fifo_rst_reg   <= 1'b0;
      reg_rdata_reg     <= '0;
      reg_error_reg     <= 1'b0;
      tx_low_prev_reg   <= 1'b0;
      rx_high_prev_reg  <= 1'b0;
      rx_level_prev_reg <= '0;
      tmo_cnt_reg       <= '0;
    end else begin
      if (wr_acc && reg_addr == A_CTRL)
        ctrl_reg <= {reg_wdata[7:6], (reg_wdata[5:4] == 2'd3) ? 2'd0 : reg_wdata[5:4],
                     reg_wdata[3:0]};
      if (wr_acc && reg_addr == A_BAUD && reg_wdata[15:0] != 16'd0)
        baud_reg <= reg_wdata[15:0];
      if (wr_acc && reg_addr == A_IEN)
        int_en_reg <= reg_wdata[5:0];
      if (wr_acc && reg_addr == A_WM) begin
        tx_wm_reg <= reg_wdata[LW-1:0];
        rx_wm_reg <= reg_wdata[8 +: LW];
      end
      if (wr_acc && reg_addr == A_TMO)
        timeout_reg <= reg_wdata[7:0];
      int_status_reg    <= int_status_next;
      sticky_reg        <= sticky_next;
      tx_fifo_rst_reg   <= wr_acc && reg_addr == A_FIFO && reg_wdata[0];
      rx_fifo_rst_reg   <= wr_acc && reg_addr == A_FIFO && reg_wdata[1];
      if (reg_ren)
        reg_rdata_reg <= rd_reject ? 32'd0 : rdata_mux;
      reg_error_reg     <= wr_reject || rd_reject;
      tx_low_prev_reg   <= tx_low_cond;
      rx_high_prev_reg  <= rx_high_cond;
      rx_level_prev_reg <= rx_level;
      tmo_cnt_reg       <= tmo_cnt_next;
    end
  end

  // Prefetch: keep one byte staged so RX_DATA reads never wait on FIFO latency.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg  <= IDLE;
      hold_data_reg <= '0;
    end else if (rx_fifo_rst_reg) begin
      rx_state_reg <= IDLE;
    end else begin
      case (rx_state_reg)
        IDLE:  if (!rx_empty) rx_state_reg <= FETCH;
        FETCH: begin
          hold_data_reg <= rx_data;
          rx_state_reg  <= HOLD;
        end
        HOLD:  if (rx_read) rx_state_reg <= rx_empty ? IDLE : FETCH;
        default: rx_state_reg <= IDLE;
      endcase
    end
  end

  assign reg_rdata    = reg_rdata_reg;
  assign reg_error    = reg_error_reg;
  assign baud_divisor = baud_reg;
  assign baud_enable  = ctrl_reg[0] | ctrl_reg[1];
  assign data_bits    = ctrl_reg[3:2];
  assign parity_mode  = ctrl_reg[5:4];
  assign stop2        = ctrl_reg[6];
  assign loopback     = ctrl_reg[7];
  assign tx_fifo_rst  = tx_fifo_rst_reg;
  assign rx_fifo_rst  = rx_fifo_rst_reg;
  assign irq          = |(int_status_reg & int_en_reg);
endmodule
